pe_feeder: RTL

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder_if.sv | 24 ++
 rtl/pe_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder_if.sv
// Weight-row and activation-vector stream handshakes feeding the PE array feeder.
// master: the producer of weight rows and activation vectors; slave: pe_feeder.
interface pe_feeder_if #(
    parameter int data_width = 18,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
);
    logic                         wgt_valid;
    logic                         wgt_ready;
    logic [data_width*COLS-1:0]   wgt_data;
    logic                         act_valid;
    logic                         act_ready;
    logic [data_width*ROWS-1:0]   act_data;

    modport master (
        output wgt_valid, wgt_data, act_valid, act_data,
        input  wgt_ready, act_ready
    );

    modport slave (
        input  wgt_valid, wgt_data, act_valid, act_data,
        output wgt_ready, act_ready
    );
endinterface

// File: rtl/pe_feeder.sv
// pe_feeder: loads ROWS weight rows into a systolic PE array (bottom row first),
// then streams num_vec activation vectors into its left edge with a per-row
// skew of 1+r cycles, drains ROWS+COLS-1 cycles of zeros and pulses done.
// Optional feature macro: FEEDER_STALL_CNT_EN enables the input-starvation
// counter on stall_cnt; without it stall_cnt is tied to zero.
module pe_feeder #(
    parameter int data_width = 18,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                num_vec,
    pe_feeder_if.slave                 feed,
    output logic                       w_en,
    output logic [data_width*COLS-1:0] in_weight_above,
    output logic                       w_compute,
    output logic [data_width*ROWS-1:0] active_left,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                stall_cnt
);

    localparam int WW         = data_width * COLS;
    localparam int AW         = data_width * ROWS;
    localparam int DRAIN_LEN  = ROWS + COLS - 1;
    localparam int DL_STAGES  = ROWS * (ROWS - 1) / 2;
    localparam int DL_W       = DL_STAGES * data_width;
    localparam logic [4:0] ROW_LAST   = 5'(ROWS - 1);
    localparam logic [5:0] DRAIN_LAST = 6'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      row_cnt_q, row_cnt_d;
    logic [15:0]     vec_cnt_q, vec_cnt_d;
    logic [5:0]      drain_cnt_q, drain_cnt_d;
    logic [15:0]     num_vec_q, num_vec_d;

    logic            wgt_ready_q, wgt_ready_d;
    logic            act_ready_q, act_ready_d;
    logic            w_en_q, w_en_d;
    logic [WW-1:0]   in_weight_above_q, in_weight_above_d;
    logic            w_compute_q, w_compute_d;
    logic [AW-1:0]   active_left_q, active_left_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DL_W-1:0] dl_q, dl_d;

    logic            wgt_acc;
    logic            act_acc;
    logic [AW-1:0]   inj;

    // Ready flops track the state register, so a handshake is simply valid && ready.
    assign wgt_acc = wgt_ready_q && feed.wgt_valid;
    assign act_acc = act_ready_q && feed.act_valid;

    // Job sequencing: next state and job counters.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        num_vec_d   = num_vec_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    num_vec_d   = num_vec;
                    row_cnt_d   = '0;
                    vec_cnt_d   = '0;
                    drain_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (wgt_acc) begin
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = (num_vec_q == '0) ? S_DONE : S_COMPUTE;
                    end else begin
                        row_cnt_d = row_cnt_q + 5'd1;
                    end
                end
            end
            S_COMPUTE: begin
                if (act_acc) begin
                    if (vec_cnt_q == num_vec_q - 16'd1) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        vec_cnt_d = vec_cnt_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered status, handshake and weight-path outputs.
    always_comb begin
        wgt_ready_d       = (state_d == S_LOAD);
        act_ready_d       = (state_d == S_COMPUTE);
        busy_d            = (state_d != S_IDLE);
        done_d            = (state_d == S_DONE);
        w_en_d            = wgt_acc;
        in_weight_above_d = wgt_acc ? feed.wgt_data : in_weight_above_q;
        w_compute_d       = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
    end

    // Activation skew: lane r is delayed r extra cycles. The delay taps are packed
    // as a triangle (lane r owns r stages starting at stage r*(r-1)/2) so no flop is dead.
    always_comb begin
        inj           = act_acc ? feed.act_data : '0;
        dl_d          = dl_q;
        active_left_d = '0;
        active_left_d[data_width-1:0] = inj[data_width-1:0];
        for (int unsigned r = 1; r < ROWS; r++) begin
            for (int unsigned k = 0; k < r; k++) begin
                if (k == 0) begin
                    dl_d[(r*(r-1)/2)*data_width +: data_width] = inj[r*data_width +: data_width];
                end else begin
                    dl_d[(r*(r-1)/2 + k)*data_width +: data_width] =
                        dl_q[(r*(r-1)/2 + k - 1)*data_width +: data_width];
                end
            end
            active_left_d[r*data_width +: data_width] =
                dl_q[(r*(r-1)/2 + r - 1)*data_width +: data_width];
        end
    end

    // State, counters, delay line and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            row_cnt_q         <= '0;
            vec_cnt_q         <= '0;
            drain_cnt_q       <= '0;
            num_vec_q         <= '0;
            wgt_ready_q       <= 1'b0;
            act_ready_q       <= 1'b0;
            w_en_q            <= 1'b0;
            in_weight_above_q <= '0;
            w_compute_q       <= 1'b0;
            active_left_q     <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            dl_q              <= '0;
        end else begin
            state_q           <= state_d;
            row_cnt_q         <= row_cnt_d;
            vec_cnt_q         <= vec_cnt_d;
            drain_cnt_q       <= drain_cnt_d;
            num_vec_q         <= num_vec_d;
            wgt_ready_q       <= wgt_ready_d;
            act_ready_q       <= act_ready_d;
            w_en_q            <= w_en_d;
            in_weight_above_q <= in_weight_above_d;
            w_compute_q       <= w_compute_d;
            active_left_q     <= active_left_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            dl_q              <= dl_d;
        end
    end

    assign feed.wgt_ready  = wgt_ready_q;
    assign feed.act_ready  = act_ready_q;
    assign w_en            = w_en_q;
    assign in_weight_above = in_weight_above_q;
    assign w_compute       = w_compute_q;
    assign active_left     = active_left_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles spent waiting on an input stream; cleared by an accepted start.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (((wgt_ready_q && !feed.wgt_valid) || (act_ready_q && !feed.act_valid))
                     && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
